// File: rtl/sequenciador_linha_param.sv
// Master sequencer for the bottling line: moves one bottle through NUM_EST stations, handles rejects,
// watchdog and batch counters. Optional SEQ_AUTOREINICIO_EN restarts the next bottle straight away.
module sequenciador_linha_param #(
    parameter int NUM_EST   = 3,
    parameter int LOTE      = 12,
    parameter int CONT_W    = 7,
    parameter int TO_W      = 24,
    parameter int TO_CICLOS = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               inibir,
    input  logic [NUM_EST:0]   sensor_pos,
    input  logic [NUM_EST-1:0] est_concluida,
    input  logic [NUM_EST-1:0] est_aprovada,
    output logic               motor,
    output logic [NUM_EST-1:0] cmd_est,
    output logic               descarte,
    output logic               inc_lote,
    output logic [CONT_W-1:0]  cont_garrafas,
    output logic [CONT_W-1:0]  cont_lotes,
    output logic               erro,
    output logic               ocupado
);
    localparam int                IDX_W     = $clog2(NUM_EST + 1);
    localparam logic [IDX_W-1:0]  IDX_SAIDA = IDX_W'(NUM_EST);
    localparam logic [TO_W-1:0]   WD_LIMITE = TO_W'(TO_CICLOS - 1);
    localparam logic [CONT_W-1:0] ULTIMA    = CONT_W'(LOTE - 1);
    localparam logic [CONT_W-1:0] LOTES_MAX = CONT_W'(99);
`ifdef SEQ_AUTOREINICIO_EN
    localparam bit AUTO_REINICIO = 1'b1;
`else
    localparam bit AUTO_REINICIO = 1'b0;
`endif

    typedef enum logic [2:0] {OCIOSO, MOVER, OPERAR, DESCARTAR, SAIDA, ERRO} estado_t;

    estado_t          estado;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  wd;
    logic [NUM_EST:0] concluida_ext;
    logic [NUM_EST:0] aprovada_ext;
    logic             timeout;

    // Station vectors padded to NUM_EST+1 bits so idx indexes sensors and stations with one width.
    assign concluida_ext = {1'b0, est_concluida};
    assign aprovada_ext  = {1'b0, est_aprovada};
    // A paused move does not age the watchdog, so it cannot expire while frozen either.
    assign timeout = (wd == WD_LIMITE) && !(estado == MOVER && inibir);

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            idx           <= '0;
            wd            <= '0;
            motor         <= 1'b0;
            cmd_est       <= '0;
            descarte      <= 1'b0;
            inc_lote      <= 1'b0;
            cont_garrafas <= '0;
            cont_lotes    <= '0;
            erro          <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            descarte <= 1'b0;
            inc_lote <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (start && !inibir) begin
                        estado  <= MOVER;
                        idx     <= '0;
                        wd      <= '0;
                        motor   <= 1'b1;
                        ocupado <= 1'b1;
                    end
                end
                MOVER: begin
                    if (timeout) begin
                        estado <= ERRO;
                        erro   <= 1'b1;
                        motor  <= 1'b0;
                    end else if (sensor_pos[idx]) begin
                        motor <= 1'b0;
                        wd    <= '0;
                        if (idx == IDX_SAIDA) begin
                            estado <= SAIDA;
                        end else begin
                            estado  <= OPERAR;
                            cmd_est <= NUM_EST'(1) << idx;
                        end
                    end else begin
                        motor <= !inibir;
                        if (!inibir) wd <= wd + 1'b1;
                    end
                end
                OPERAR: begin
                    if (timeout) begin
                        estado  <= ERRO;
                        erro    <= 1'b1;
                        cmd_est <= '0;
                    end else if (concluida_ext[idx]) begin
                        cmd_est <= '0;
                        if (!aprovada_ext[idx]) begin
                            estado   <= DESCARTAR;
                            descarte <= 1'b1;
                        end else begin
                            estado <= MOVER;
                            idx    <= idx + 1'b1;
                            wd     <= '0;
                            motor  <= !inibir;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DESCARTAR: begin
                    if (AUTO_REINICIO && !inibir) begin
                        estado <= MOVER;
                        idx    <= '0;
                        wd     <= '0;
                        motor  <= 1'b1;
                    end else begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                end
                SAIDA: begin
                    if (cont_garrafas == ULTIMA) begin
                        cont_garrafas <= '0;
                        inc_lote      <= 1'b1;
                        if (cont_lotes != LOTES_MAX) cont_lotes <= cont_lotes + 1'b1;
                    end else begin
                        cont_garrafas <= cont_garrafas + 1'b1;
                    end
                    if (AUTO_REINICIO && !inibir) begin
                        estado <= MOVER;
                        idx    <= '0;
                        wd     <= '0;
                        motor  <= 1'b1;
                    end else begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                end
                ERRO: begin
                    if (start) begin
                        estado  <= OCIOSO;
                        erro    <= 1'b0;
                        ocupado <= 1'b0;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_linha_param.sv
// Scoreboard bench for sequenciador_linha_param: driver pushes expected events, a monitor pops and
// compares them whenever the DUT shows a command, reject, bottle exit or watchdog fault.
module tb_sequenciador_linha_param;
    localparam int NUM_EST   = 3;
    localparam int LOTE      = 12;
    localparam int CONT_W    = 7;
    localparam int TO_W      = 8;
    localparam int TO_CICLOS = 16;
    localparam int NB        = NUM_EST + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               inibir = 1'b0;
    logic [NUM_EST:0]   sensor_pos = '0;
    logic [NUM_EST-1:0] est_concluida = '0;
    logic [NUM_EST-1:0] est_aprovada = '0;
    logic               motor;
    logic [NUM_EST-1:0] cmd_est;
    logic               descarte;
    logic               inc_lote;
    logic [CONT_W-1:0]  cont_garrafas;
    logic [CONT_W-1:0]  cont_lotes;
    logic               erro;
    logic               ocupado;

    sequenciador_linha_param #(
        .NUM_EST(NUM_EST), .LOTE(LOTE), .CONT_W(CONT_W), .TO_W(TO_W), .TO_CICLOS(TO_CICLOS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .inibir(inibir), .sensor_pos(sensor_pos),
        .est_concluida(est_concluida), .est_aprovada(est_aprovada), .motor(motor),
        .cmd_est(cmd_est), .descarte(descarte), .inc_lote(inc_lote),
        .cont_garrafas(cont_garrafas), .cont_lotes(cont_lotes), .erro(erro), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_CMD, EV_DESC, EV_SAIDA, EV_ERRO} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cmd;
        int       cont;
        int       inc;
        int       lotes;
    } ev_t;

    ev_t esperados[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  good = 0;  // approved bottles that reached the exit since the last reset

    task automatic check(input string name, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Reference model: batch counters follow directly from the number of good bottles.
    task automatic push_ev(input ev_kind_t kind, input int cmd);
        ev_t e;
        e.kind  = kind;
        e.cmd   = cmd;
        e.cont  = good % LOTE;
        e.inc   = (kind == EV_SAIDA && good % LOTE == 0) ? 1 : 0;
        e.lotes = (good / LOTE > 99) ? 99 : good / LOTE;
        esperados.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_t kind, input string name);
        ev_t e;
        check({name, "_pending"}, esperados.size() > 0, 1);
        if (esperados.size() > 0) begin
            e = esperados.pop_front();
            check({name, "_kind"}, int'(kind), int'(e.kind));
            case (kind)
                EV_CMD: begin
                    check("cmd_onehot", cmd_est, e.cmd);
                    check("cmd_motor_off", motor, 0);
                end
                EV_DESC:  check("desc_cmd_clear", cmd_est, 0);
                EV_SAIDA: begin
                    check("saida_cont_garrafas", cont_garrafas, e.cont);
                    check("saida_inc_lote", inc_lote, e.inc);
                    check("saida_cont_lotes", cont_lotes, e.lotes);
                end
                EV_ERRO: begin
                    check("erro_motor_off", motor, 0);
                    check("erro_cmd_off", cmd_est, 0);
                end
                default: ;
            endcase
        end
    endtask

    logic [NUM_EST-1:0] prev_cmd = '0;
    logic [CONT_W-1:0]  prev_cont = '0;
    logic [CONT_W-1:0]  prev_lotes = '0;
    logic               prev_erro = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (cmd_est != '0 && prev_cmd == '0) expect_ev(EV_CMD, "cmd");
                if (descarte) expect_ev(EV_DESC, "descarte");
                if (cont_garrafas != prev_cont || inc_lote || cont_lotes != prev_lotes)
                    expect_ev(EV_SAIDA, "saida");
                if (erro && !prev_erro) expect_ev(EV_ERRO, "erro");
            end
            prev_cmd   = cmd_est;
            prev_cont  = cont_garrafas;
            prev_lotes = cont_lotes;
            prev_erro  = erro;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_motor"}, motor, 0);
        check({tag, "_cmd_est"}, cmd_est, 0);
        check({tag, "_descarte"}, descarte, 0);
        check({tag, "_inc_lote"}, inc_lote, 0);
        check({tag, "_cont_garrafas"}, cont_garrafas, 0);
        check({tag, "_cont_lotes"}, cont_lotes, 0);
        check({tag, "_erro"}, erro, 0);
        check({tag, "_ocupado"}, ocupado, 0);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (ocupado && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", ocupado, 0);
    endtask

    task automatic run_bottle(input logic [NUM_EST-1:0] ok, input bit pause, output bit aprovada);
        aprovada = 1'b0;
        wait_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_motor", motor, 1);
        if (pause) begin
            inibir = 1'b1;
            @(negedge clk);
            check("pause_motor", motor, 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("pause_start_motor", motor, 0);
            check("pause_ocupado", ocupado, 1);
            inibir = 1'b0;
            @(negedge clk);
            check("release_motor", motor, 1);
        end
        for (int i = 0; i < NUM_EST; i++) begin
            repeat ($urandom_range(0, 3)) begin
                sensor_pos = NB'($urandom) & ~(NB'(1) << i);
                @(negedge clk);
            end
            push_ev(EV_CMD, 1 << i);
            sensor_pos = NB'(1) << i;
            @(negedge clk);
            sensor_pos = '0;
            repeat ($urandom_range(0, 3)) begin
                est_concluida = NUM_EST'($urandom) & ~(NUM_EST'(1) << i);
                est_aprovada  = NUM_EST'($urandom);
                @(negedge clk);
            end
            est_concluida = NUM_EST'(1) << i;
            est_aprovada  = ok[i] ? (NUM_EST'($urandom) | (NUM_EST'(1) << i))
                                  : (NUM_EST'($urandom) & ~(NUM_EST'(1) << i));
            if (!ok[i]) push_ev(EV_DESC, 0);
            @(negedge clk);
            est_concluida = '0;
            est_aprovada  = '0;
            check("done_cmd_clear", cmd_est, 0);
            if (!ok[i]) return;
            check("done_motor", motor, 1);
        end
        repeat ($urandom_range(0, 3)) begin
            sensor_pos = NB'($urandom) & ~(NB'(1) << NUM_EST);
            @(negedge clk);
        end
        good++;
        push_ev(EV_SAIDA, 0);
        sensor_pos = NB'(1) << NUM_EST;
        @(negedge clk);
        sensor_pos = '0;
        @(negedge clk);
        aprovada = 1'b1;
    endtask

    task automatic watchdog_run(input int freeze);
        int first = 0;
        wait_idle();
        push_ev(EV_ERRO, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (erro) begin
                first = n;
                break;
            end
            inibir     = (n >= 3 && n < 3 + freeze);
            sensor_pos = NB'($urandom) & ~NB'(1);
            @(negedge clk);
        end
        inibir     = 1'b0;
        sensor_pos = '0;
        // MOVER is entered one cycle after start; the fault shows one cycle after the last count.
        check("wd_latency", first, TO_CICLOS + 1 + freeze);
        check("wd_ocupado", ocupado, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("erro_clear", erro, 0);
        check("erro_ocupado_clear", ocupado, 0);
        check("erro_cont_kept", cont_garrafas, good % LOTE);
        check("erro_lotes_kept", cont_lotes, (good / LOTE > 99) ? 99 : good / LOTE);
    endtask

    initial begin : guard
        #900_000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1);
    end

    initial begin : driver
        bit a;
        logic [NUM_EST-1:0] mask;
        int iter;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // start while paused is dropped
        inibir = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("start_dropped_ocupado", ocupado, 0);
        inibir = 1'b0;
        @(negedge clk);

        for (int b = 0; b < 5; b++) run_bottle('1, b == 0, a);

        // reset in the middle of station 0 with five bottles counted
        wait_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_ev(EV_CMD, 1);
        sensor_pos = NB'(1);
        @(negedge clk);
        sensor_pos = '0;
        check("pre_reset_cont", cont_garrafas, 5);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        esperados.delete();
        good  = 0;
        reset = 1'b0;
        @(negedge clk);

        run_bottle('1, 1'b0, a);
        check("normal_cont", cont_garrafas, 1);

        run_bottle(3'b101, 1'b0, a);
        wait_idle();
        check("reject_cont_kept", cont_garrafas, 1);

        watchdog_run(0);
        watchdog_run(5);

        iter = 0;
        while (good < LOTE * 100 + 3 && iter < 3000) begin
            for (int s = 0; s < NUM_EST; s++) mask[s] = ($urandom_range(0, 15) != 0);
            run_bottle(mask, $urandom_range(0, 19) == 0, a);
            if (!a) begin
                wait_idle();
                check("rand_reject_cont", cont_garrafas, good % LOTE);
            end
            iter++;
        end
        check("lotes_saturated", cont_lotes, 99);

        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", esperados.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
